// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - opcode values, control bundle and decode helpers for id_stage_p
package id_pkg;

  localparam logic [15:0] OP_NOP   = 16'd0;
  localparam logic [15:0] OP_LOAD  = 16'd1;
  localparam logic [15:0] OP_STORE = 16'd2;
  localparam logic [15:0] OP_ALU   = 16'd3;
  localparam logic [15:0] OP_ADDI  = 16'd4;
  localparam logic [15:0] OP_JMP   = 16'd5;
  localparam logic [15:0] OP_BEQ   = 16'd6;
  localparam logic [15:0] OP_BNE   = 16'd7;
  localparam logic [15:0] OP_IN    = 16'd8;
  localparam logic [15:0] OP_OUT   = 16'd9;

  typedef struct packed {
    logic j;
    logic jc;
    logic ina;
    logic rm;
    logic wm;
    logic sin;
    logic sout;
    logic wrout;
    logic neq;
    logic illegal;
  } ctrl_t;

  // The opcode is zero-extended to 16 bits so one decoder serves any OPW up to 16.
  function automatic ctrl_t decode(input logic [15:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_NOP:   c = '0;
      OP_LOAD:  begin c.rm = 1'b1; c.wrout = 1'b1; end
      OP_STORE: c.wm = 1'b1;
      OP_ALU:   c.wrout = 1'b1;
      OP_ADDI:  begin c.ina = 1'b1; c.wrout = 1'b1; end
      OP_JMP:   c.j = 1'b1;
      OP_BEQ:   c.jc = 1'b1;
      OP_BNE:   begin c.jc = 1'b1; c.neq = 1'b1; end
      OP_IN:    begin c.sin = 1'b1; c.wrout = 1'b1; end
      OP_OUT:   c.sout = 1'b1;
      default:  c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  function automatic logic reads_ra(input logic [15:0] op);
    return !((op == OP_NOP) || (op == OP_JMP) || (op == OP_IN));
  endfunction

endpackage

// File: rtl/regfile_p.sv
// rtl/regfile_p.sv - NREG x DW register file, one write port, one async read port with write bypass
module regfile_p #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int RW   = $clog2(NREG)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic [RW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [RW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [NREG];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // A same-cycle write to the addressed register is forwarded to the reader.
  assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];

endmodule

// File: rtl/id_stage_p.sv
// rtl/id_stage_p.sv - instruction decode stage with register file, hazard detect and ID/EX register
module id_stage_p
  import id_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int OPW  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DW-1:0]           PC,
  input  logic [DW-1:0]           inst,
  input  logic                    wb_we,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic [DW-1:0]           wb_data,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    ready_out,
  output logic                    hazard_stall,
  output logic                    out_valid,
  output logic [DW-1:0]           PCout,
  output logic [DW-1:0]           regVal,
  output logic [DW-1:0]           extsinal,
  output logic [2:0]              funct,
  output logic [$clog2(NREG)-1:0] rd_out,
  output logic                    J,
  output logic                    JC,
  output logic                    INA,
  output logic                    RM,
  output logic                    WM,
  output logic                    SIN,
  output logic                    SOUT,
  output logic                    WROut,
  output logic                    NEQ,
  output logic                    illegal
);

  localparam int RW   = $clog2(NREG);
  localparam int IMMW = DW - OPW - RW;

  logic [OPW-1:0]  w_op;
  logic [RW-1:0]   w_ra;
  logic [IMMW-1:0] w_imm;
  logic [15:0]     w_op_ext;
  logic [DW-1:0]   w_operand;
  logic [DW-1:0]   w_ext;
  ctrl_t           w_dec;
  logic            w_reads;
  logic            w_hazard;

  logic            r_valid;
  logic [DW-1:0]   r_pc;
  logic [DW-1:0]   r_regval;
  logic [DW-1:0]   r_ext;
  logic [2:0]      r_funct;
  logic [RW-1:0]   r_rd;
  ctrl_t           r_ctrl;

  assign w_op     = inst[DW-1 -: OPW];
  assign w_ra     = inst[IMMW+RW-1 : IMMW];
  assign w_imm    = inst[IMMW-1:0];
  assign w_op_ext = 16'(w_op);
  assign w_dec    = decode(w_op_ext);
  assign w_reads  = reads_ra(w_op_ext);
  assign w_ext    = {{(DW-IMMW){w_imm[IMMW-1]}}, w_imm};

  regfile_p #(
    .DW   (DW),
    .NREG (NREG),
    .RW   (RW)
  ) u_regfile (
    .i_clock (clock),
    .i_reset (reset),
    .i_we    (wb_we),
    .i_waddr (wb_addr),
    .i_wdata (wb_data),
    .i_raddr (w_ra),
    .o_rdata (w_operand)
  );

  // A load sitting in ID/EX cannot forward its data in time to a dependent reader.
  assign w_hazard = in_valid & r_valid & r_ctrl.rm & (r_rd == w_ra) & w_reads;

  assign hazard_stall = w_hazard;
  assign ready_out    = ~stall & ~w_hazard;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_regval <= '0;
      r_ext    <= '0;
      r_funct  <= '0;
      r_rd     <= '0;
      r_ctrl   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (stall) begin
      r_valid <= r_valid;
    end else if (w_hazard || !in_valid) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_valid  <= 1'b1;
      r_pc     <= PC;
      r_regval <= w_operand;
      r_ext    <= w_ext;
      r_funct  <= inst[2:0];
      r_rd     <= w_ra;
      r_ctrl   <= w_dec;
    end
  end

  assign out_valid = r_valid;
  assign PCout     = r_pc;
  assign regVal    = r_regval;
  assign extsinal  = r_ext;
  assign funct     = r_funct;
  assign rd_out    = r_rd;
  assign J         = r_ctrl.j;
  assign JC        = r_ctrl.jc;
  assign INA       = r_ctrl.ina;
  assign RM        = r_ctrl.rm;
  assign WM        = r_ctrl.wm;
  assign SIN       = r_ctrl.sin;
  assign SOUT      = r_ctrl.sout;
  assign WROut     = r_ctrl.wrout;
  assign NEQ       = r_ctrl.neq;
  assign illegal   = r_ctrl.illegal;

endmodule

// File: tb/tb_id_stage_p.sv
// tb/tb_id_stage_p.sv - self-checking bench for id_stage_p with a behavioural reference model
module tb_id_stage_p;

  logic       clock, reset, in_valid, wb_we, stall, flush;
  logic [7:0] PC, inst, wb_data;
  logic [1:0] wb_addr;
  logic       ready_out, hazard_stall, out_valid;
  logic [7:0] PCout, regVal, extsinal;
  logic [2:0] funct;
  logic [1:0] rd_out;
  logic       J, JC, INA, RM, WM, SIN, SOUT, WROut, NEQ, illegal;
  logic [9:0] dut_ctrl;

  int checks = 0;
  int errors = 0;

  localparam int B_J = 9, B_JC = 8, B_INA = 7, B_RM = 6, B_WM = 5;
  localparam int B_SIN = 4, B_SOUT = 3, B_WR = 2, B_NEQ = 1, B_ILL = 0;

  logic [7:0] m_regs [4];
  logic       m_valid;
  logic [7:0] m_pc, m_regval, m_ext;
  logic [2:0] m_funct;
  logic [1:0] m_rd;
  logic [9:0] m_ctrl;

  id_stage_p #(.DW(8), .NREG(4), .OPW(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .PC(PC), .inst(inst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall), .flush(flush),
    .ready_out(ready_out), .hazard_stall(hazard_stall), .out_valid(out_valid),
    .PCout(PCout), .regVal(regVal), .extsinal(extsinal), .funct(funct), .rd_out(rd_out),
    .J(J), .JC(JC), .INA(INA), .RM(RM), .WM(WM), .SIN(SIN), .SOUT(SOUT),
    .WROut(WROut), .NEQ(NEQ), .illegal(illegal)
  );

  assign dut_ctrl = {J, JC, INA, RM, WM, SIN, SOUT, WROut, NEQ, illegal};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [9:0] exp_ctrl(input logic [3:0] op);
    logic [9:0] one = 10'd1;
    case (op)
      4'd0: return 10'd0;
      4'd1: return (one << B_RM) | (one << B_WR);
      4'd2: return one << B_WM;
      4'd3: return one << B_WR;
      4'd4: return (one << B_INA) | (one << B_WR);
      4'd5: return one << B_J;
      4'd6: return one << B_JC;
      4'd7: return (one << B_JC) | (one << B_NEQ);
      4'd8: return (one << B_SIN) | (one << B_WR);
      4'd9: return one << B_SOUT;
      default: return one << B_ILL;
    endcase
  endfunction

  function automatic logic m_reads(input logic [3:0] op);
    return !(op == 4'd0 || op == 4'd5 || op == 4'd8);
  endfunction

  function automatic logic m_hz();
    return in_valid && m_valid && m_ctrl[B_RM] && (m_rd == inst[3:2]) && m_reads(inst[7:4]);
  endfunction

  task automatic apply(input logic rst, input logic v, input logic [7:0] pc, input logic [7:0] ins,
                       input logic we, input logic [1:0] wa, input logic [7:0] wd,
                       input logic st, input logic fl);
    @(negedge clock);
    reset = rst; in_valid = v; PC = pc; inst = ins;
    wb_we = we; wb_addr = wa; wb_data = wd; stall = st; flush = fl;
    #1;
  endtask

  // Advance the model by one clock using the inputs currently applied, then let the DUT take the edge.
  task automatic tick();
    logic       hz;
    logic [7:0] opnd;
    hz   = m_hz();
    opnd = (wb_we && wb_addr == inst[3:2]) ? wb_data : m_regs[inst[3:2]];
    if (reset) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_valid = 0; m_pc = 0; m_regval = 0; m_ext = 0; m_funct = 0; m_rd = 0; m_ctrl = 0;
    end else begin
      if (flush) begin
        m_valid = 0; m_ctrl = 0;
      end else if (!stall) begin
        if (hz || !in_valid) begin
          m_valid = 0; m_ctrl = 0;
        end else begin
          m_valid  = 1;
          m_pc     = PC;
          m_regval = opnd;
          m_ext    = 8'($signed(inst[1:0]));
          m_funct  = inst[2:0];
          m_rd     = inst[3:2];
          m_ctrl   = exp_ctrl(inst[7:4]);
        end
      end
      if (wb_we) m_regs[wb_addr] = wb_data;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    apply(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0);
    tick();
    tick();
    checks++;
    if ({out_valid, PCout, regVal, extsinal, funct, rd_out, dut_ctrl} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b pc=%h rv=%h ext=%h ctrl=%b want all zero",
               out_valid, PCout, regVal, extsinal, dut_ctrl);
    end
  endtask

  task automatic test_alu_bypass();
    apply(0, 1, 8'h01, 8'h38, 0, 0, 8'h00, 0, 0);
    tick();
    checks++;
    if ({out_valid, regVal, dut_ctrl} !== {1'b1, 8'h00, 10'b0000000100}) begin
      errors++;
      $display("FAIL alu_first got v=%b rv=%h ctrl=%b want v=1 rv=00 ctrl=0000000100", out_valid, regVal, dut_ctrl);
    end
    apply(0, 0, 8'h02, 8'h00, 1, 2'd2, 8'h55, 0, 0);
    tick();
    apply(0, 1, 8'h03, 8'h38, 0, 0, 8'h00, 0, 0);
    tick();
    checks++;
    if (regVal !== 8'h55) begin
      errors++;
      $display("FAIL regfile_write got %h want 55", regVal);
    end
    apply(0, 1, 8'h04, 8'h38, 1, 2'd2, 8'h5F, 0, 0);
    tick();
    checks++;
    if (regVal !== 8'h5F) begin
      errors++;
      $display("FAIL wb_bypass got %h want 5f", regVal);
    end
  endtask

  task automatic test_imm_decode();
    apply(0, 1, 8'h05, 8'h43, 0, 0, 8'h00, 0, 0);
    tick();
    checks++;
    if ({extsinal, dut_ctrl} !== {8'hFF, 10'b0010000100}) begin
      errors++;
      $display("FAIL addi_neg_imm got ext=%h ctrl=%b want ext=ff ctrl=0010000100", extsinal, dut_ctrl);
    end
    apply(0, 1, 8'h06, 8'h41, 0, 0, 8'h00, 0, 0);
    tick();
    checks++;
    if (extsinal !== 8'h01) begin
      errors++;
      $display("FAIL addi_pos_imm got %h want 01", extsinal);
    end
    apply(0, 1, 8'h07, 8'h78, 0, 0, 8'h00, 0, 0);
    tick();
    checks++;
    if (dut_ctrl !== 10'b0100000010) begin
      errors++;
      $display("FAIL bne_ctrl got %b want 0100000010", dut_ctrl);
    end
  endtask

  task automatic test_hazard();
    apply(0, 1, 8'h08, 8'h14, 0, 0, 8'h00, 0, 0);
    tick();
    apply(0, 1, 8'h09, 8'h34, 0, 0, 8'h00, 0, 0);
    checks++;
    if ({hazard_stall, ready_out} !== 2'b10) begin
      errors++;
      $display("FAIL load_use_detect got hz=%b rdy=%b want hz=1 rdy=0", hazard_stall, ready_out);
    end
    tick();
    checks++;
    if ({out_valid, dut_ctrl} !== 11'd0) begin
      errors++;
      $display("FAIL hazard_bubble got v=%b ctrl=%b want v=0 ctrl=0", out_valid, dut_ctrl);
    end
    checks++;
    if ({hazard_stall, ready_out} !== 2'b01) begin
      errors++;
      $display("FAIL hazard_release got hz=%b rdy=%b want hz=0 rdy=1", hazard_stall, ready_out);
    end
    tick();
    checks++;
    if ({out_valid, dut_ctrl, rd_out, PCout} !== {1'b1, 10'b0000000100, 2'd1, 8'h09}) begin
      errors++;
      $display("FAIL hazard_retry got v=%b ctrl=%b rd=%0d pc=%h want v=1 ctrl=0000000100 rd=1 pc=09",
               out_valid, dut_ctrl, rd_out, PCout);
    end
  endtask

  task automatic test_stall_flush();
    apply(0, 1, 8'h10, 8'h20, 0, 0, 8'h00, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 8'h11 + 8'(i), 8'($urandom), 0, 0, 8'h00, 1, 0);
      tick();
      checks++;
      if ({out_valid, PCout, dut_ctrl} !== {1'b1, 8'h10, 10'b0000100000}) begin
        errors++;
        $display("FAIL stall_hold_%0d got v=%b pc=%h ctrl=%b want v=1 pc=10 ctrl=0000100000",
                 i, out_valid, PCout, dut_ctrl);
      end
    end
    apply(0, 1, 8'h20, 8'h30, 0, 0, 8'h00, 1, 1);
    tick();
    checks++;
    if ({out_valid, WM, PCout} !== {1'b0, 1'b0, 8'h10}) begin
      errors++;
      $display("FAIL flush_over_stall got v=%b wm=%b pc=%h want v=0 wm=0 pc=10", out_valid, WM, PCout);
    end
    apply(0, 1, 8'h21, 8'h24, 0, 0, 8'h00, 0, 0);
    tick();
    apply(1, 1, 8'h22, 8'h38, 0, 0, 8'h00, 1, 0);
    tick();
    checks++;
    if ({out_valid, PCout, regVal, extsinal, funct, rd_out, dut_ctrl} !== 40'd0) begin
      errors++;
      $display("FAIL reset_mid_stall got v=%b pc=%h ctrl=%b want all zero", out_valid, PCout, dut_ctrl);
    end
    apply(0, 0, 8'h23, 8'h30, 0, 0, 8'h00, 0, 0);
    tick();
    apply(0, 1, 8'h24, 8'h30, 1, 2'd0, 8'hA5, 1, 0);
    tick();
    checks++;
    if ({out_valid, regVal} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL wb_in_stall_hold got v=%b rv=%h want v=0 rv=00", out_valid, regVal);
    end
    apply(0, 1, 8'h25, 8'h30, 0, 0, 8'h00, 0, 0);
    tick();
    checks++;
    if (regVal !== 8'hA5) begin
      errors++;
      $display("FAIL wb_in_stall_stored got %h want a5", regVal);
    end
  endtask

  task automatic test_illegal();
    apply(0, 1, 8'h30, 8'hF0, 0, 0, 8'h00, 0, 0);
    tick();
    checks++;
    if ({out_valid, dut_ctrl} !== {1'b1, 10'b0000000001}) begin
      errors++;
      $display("FAIL illegal_op got v=%b ctrl=%b want v=1 ctrl=0000000001", out_valid, dut_ctrl);
    end
    apply(0, 0, 8'h31, 8'h38, 0, 0, 8'h00, 0, 0);
    tick();
    checks++;
    if ({out_valid, dut_ctrl} !== 11'd0) begin
      errors++;
      $display("FAIL invalid_bubble got v=%b ctrl=%b want v=0 ctrl=0", out_valid, dut_ctrl);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'd1 : 4'($urandom_range(0, 15));
      apply($urandom_range(0, 59) == 0, $urandom_range(0, 4) != 0, 8'($urandom),
            {op, 4'($urandom)}, $urandom_range(0, 1) == 1, 2'($urandom), 8'($urandom),
            $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);
      checks++;
      if ({hazard_stall, ready_out} !== {m_hz(), !stall && !m_hz()}) begin
        errors++;
        $display("FAIL rand_comb_%0d got hz=%b rdy=%b want hz=%b rdy=%b",
                 n, hazard_stall, ready_out, m_hz(), !stall && !m_hz());
      end
      tick();
      checks++;
      if ({out_valid, PCout, regVal, extsinal, funct, rd_out, dut_ctrl} !==
          {m_valid, m_pc, m_regval, m_ext, m_funct, m_rd, m_ctrl}) begin
        errors++;
        $display("FAIL rand_regs_%0d got v=%b pc=%h rv=%h ext=%h f=%0d rd=%0d ctrl=%b want v=%b pc=%h rv=%h ext=%h f=%0d rd=%0d ctrl=%b",
                 n, out_valid, PCout, regVal, extsinal, funct, rd_out, dut_ctrl,
                 m_valid, m_pc, m_regval, m_ext, m_funct, m_rd, m_ctrl);
      end
    end
  endtask

  initial begin
    reset = 1; in_valid = 0; PC = 0; inst = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0; stall = 0; flush = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_valid = 0; m_pc = 0; m_regval = 0; m_ext = 0; m_funct = 0; m_rd = 0; m_ctrl = 0;
    test_reset();
    test_alu_bypass();
    test_imm_decode();
    test_hazard();
    test_stall_flush();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_p.md
Name: id_stage_p

Overview:
- Parametrised successor to the single-width instruction-decode stage of the 8-bit processor.
- Contains the register file, write-back bypass, opcode decode, sign extension and load-use hazard detection.
- Its outputs are registered as the ID/EX pipeline register, with valid, stall and flush control.
- Sits between the IF stage (supplies PC/inst) and the EX stage; write-back returns via wb_* ports.

Parameters:
- DW, 8, data/instruction/PC width.
- NREG, 4, register count (power of 2, >=2); RW = $clog2(NREG).
- OPW, 4, opcode field width; IMMW = DW-OPW-RW, must be >=1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  PC/inst valid from IF.
- PC  in  DW  PC of instruction.
- inst  in  DW  instruction.
- wb_we  in  1  write-back enable (WR).
- wb_addr  in  RW  write-back register.
- wb_data  in  DW  write-back data.
- stall  in  1  downstream hold.
- flush  in  1  kill instruction entering ID/EX.
- ready_out  out  1  ID accepts inst this cycle (comb).
- hazard_stall  out  1  load-use detected (comb).
- out_valid  out  1  ID/EX valid.
- PCout  out  DW  registered PC.
- regVal  out  DW  operand value.
- extsinal  out  DW  sign-extended immediate.
- funct  out  3  inst[2:0].
- rd_out  out  RW  register field.
- J, JC, INA, RM, WM, SIN, SOUT, WROut, NEQ  out  1 each  control.
- illegal  out  1  undefined opcode.

Behaviour:
- Fields: op = inst[DW-1 -: OPW]; ra = inst[IMMW+RW-1 : IMMW]; imm = inst[IMMW-1:0]; funct = inst[2:0]. Fields may overlap; EX selects by opcode.
- ra is both source and destination.
- Register file: NREG x DW; all entries cleared on reset; written on the rising edge when wb_we=1; all entries writable.
- Read bypass: if wb_we=1 and wb_addr==ra in the same cycle, the operand is wb_data, not the stored value.
- extsinal = imm sign-extended to DW.
- Decode (op value -> asserted signals; all others 0):
  - 0 NOP: none.
  - 1 LOAD: RM, WROut.
  - 2 STORE: WM.
  - 3 ALU: WROut.
  - 4 ADDI: INA, WROut.
  - 5 JMP: J.
  - 6 BEQ: JC.
  - 7 BNE: JC, NEQ.
  - 8 IN: SIN, WROut.
  - 9 OUT: SOUT.
  - >=10: all 0, illegal=1.
- Reads ra: every op except NOP, JMP and IN.
- Load-use hazard: hazard_stall = in_valid & out_valid & RM(registered) & (rd_out==ra) & reads_ra.
- ready_out = !stall & !hazard_stall.
- ID/EX update priority each rising edge:
  - reset: all outputs 0.
  - else flush: out_valid=0, all control and illegal 0, data fields hold.
  - else stall: hold every output.
  - else hazard_stall or !in_valid: bubble (out_valid=0, control and illegal 0, data fields hold).
  - else load: out_valid=1 and all decoded values.
- Latency: 1 cycle from inst to outputs.
- A bubble never asserts any control output.
- Reset mid-stall clears everything; no pending state survives.
- Flush with stall: flush wins.
- Write-back during stall still updates the register file. regVal is captured only on load, so the held value is not refreshed.

Decomposition:
- Package id_pkg: opcode localparams (OP_NOP..OP_OUT); a ctrl_t struct holding the nine control bits plus illegal; function decode(op) -> ctrl_t; function reads_ra(op).
- One sub-module, regfile_p (DW, NREG): synchronous reset, 1 write port, 1 async read port, with bypass.

Test Plan (DW=8, NREG=4; IMMW=2, ra=inst[3:2]):
- Reset held 2 cycles -> all outputs 0; then inst=0x38 (ALU, ra=2), in_valid=1 -> regVal=0x00, WROut=1, out_valid=1.
- wb_we=1, wb_addr=2, wb_data=0x55 for one cycle; next cycle inst=0x38 -> regVal=0x55. Same-cycle wb (2, 0x5F) with inst=0x38 -> regVal=0x5F (bypass).
- inst=0x43 -> extsinal=0xFF, INA=1, WROut=1. inst=0x41 -> extsinal=0x01. inst=0x78 -> JC=1, NEQ=1.
- inst=0x14 (LOAD, ra=1), then inst=0x34 -> hazard_stall=1, ready_out=0; next edge out_valid=0 with all control 0. Following cycle the ALU loads with out_valid=1, WROut=1.
- Load inst=0x20, then stall=1 for 3 cycles with inst changing -> outputs hold WM=1, PCout unchanged. stall=1 and flush=1 together -> out_valid=0, WM=0.
- inst=0xF0 -> illegal=1, all control 0, out_valid=1. in_valid=0 -> out_valid=0.
